led_pattern_master: RTL

AXI4-Lite master that sits directly upstream of the LED register slave and drives its AXI4-Lite slave port. At each programmable interval it writes the current 16-bit LED pattern to the LED register, then reads the register back and checks it. After each transaction it rotates the pattern left or right, giving a self-checking "chaser" demo with no CPU.

---
 rtl/led_pattern_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_master.sv
// AXI4-Lite chaser master: writes a rotating 16-bit pattern to the LED
// register every TICKS cycles, reads it back and counts mismatches.
//
// Ports:
//   clk, resetn        clock, async active-low reset
//   enable, direction  tick gate, rotate dir (0 left / 1 right)
//   pattern            pattern for the next or in-flight transaction
//   busy               FSM not idle
//   error_count        saturating count of failed transactions
//   last_error         most recent completed transaction failed
//   M_AXI_*            AXI4-Lite master port
module led_pattern_master #(
  parameter int              AW           = 32,
  parameter logic [AW-1:0]   LED_ADDR     = '0,
  parameter int              TICKS        = 25000000,
  parameter logic [15:0]     INIT_PATTERN = 16'h0001
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          direction,
  output logic [15:0]   pattern,
  output logic          busy,
  output logic [15:0]   error_count,
  output logic          last_error,
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [2:0]    M_AXI_AWPROT,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic          M_AXI_RVALID,
  input  logic [1:0]    M_AXI_RRESP,
  output logic          M_AXI_RREADY
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_B,
    S_READ,
    S_WAIT_R
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic [15:0]   pattern_q;
  logic [15:0]   ec_q;
  logic          last_err_q;
  logic          wfail_q;
  logic          awvalid_q, wvalid_q, bready_q;
  logic          arvalid_q, rready_q;

  logic tick, launch;
  logic aw_done, w_done;
  logic rd_fail;
  logic unused_rdata;

  assign tick   = (cnt_q == LAST);
  assign launch = (state_q == S_IDLE) && pending_q;

  // A handshake is complete once VALID has been dropped or is being
  // accepted this cycle; AW and W may finish in either order.
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  assign rd_fail = wfail_q || (M_AXI_RRESP != 2'b00) ||
                   (M_AXI_RDATA[15:0] != pattern_q);

  assign unused_rdata = ^M_AXI_RDATA[31:16];

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // A tick landing on the launch cycle still counts, so set wins.
  always_comb begin
    pending_d = pending_q;
    if (launch)
      pending_d = 1'b0;
    if (tick && enable)
      pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      pattern_q  <= INIT_PATTERN;
      ec_q       <= 16'h0000;
      last_err_q <= 1'b0;
      wfail_q    <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      unique case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (awvalid_q && M_AXI_AWREADY)
            awvalid_q <= 1'b0;
          if (wvalid_q && M_AXI_WREADY)
            wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (M_AXI_BVALID) begin
            wfail_q   <= (M_AXI_BRESP != 2'b00);
            bready_q  <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (M_AXI_RVALID) begin
            rready_q   <= 1'b0;
            last_err_q <= rd_fail;
            if (rd_fail && ec_q != 16'hFFFF)
              ec_q <= ec_q + 16'd1;
            pattern_q <= direction ?
              {pattern_q[0], pattern_q[15:1]} :
              {pattern_q[14:0], pattern_q[15]};
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pattern       = pattern_q;
  assign busy          = (state_q != S_IDLE);
  assign error_count   = ec_q;
  assign last_error    = last_err_q;
  assign M_AXI_AWADDR  = LED_ADDR;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = {16'h0000, pattern_q};
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = LED_ADDR;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;

endmodule
